// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: bus widths, handshake
// levels and the FSM state encoding.
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div.sv
// Restoring shift/subtract divider, one quotient bit per cycle (32 cycles),
// signed operands handled by dividing magnitudes and fixing signs at the end.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e              state_q;
  logic [5:0]              cnt_q;
  logic [64:0]             work_q;
  logic [64:0]             work_d;
  logic [RegBus-1:0]       divisor_q;
  logic                    signed_q;
  logic                    op1_neg_q;
  logic                    op2_neg_q;
  logic [DoubleRegBus-1:0] result_q;
  logic                    ready_q;

  logic [32:0]             trial;
  logic [RegBus-1:0]       op1_abs;
  logic [RegBus-1:0]       op2_abs;
  logic [RegBus-1:0]       quot_raw;
  logic [RegBus-1:0]       rem_raw;
  logic [RegBus-1:0]       quot_fin;
  logic [RegBus-1:0]       rem_fin;

  assign op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Partial remainder sits in work[63:32]; a borrow out of the trial means
  // the divisor did not fit and the quotient bit shifted in is 0.
  assign trial  = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
  assign work_d = trial[32] ? {work_q[63:0], 1'b0}
                            : {trial[31:0], work_q[31:0], 1'b1};

  assign quot_raw = work_q[31:0];
  assign rem_raw  = work_q[64:33];
  assign quot_fin = (signed_q && (op1_neg_q ^ op2_neg_q)) ? (~quot_raw + 32'd1) : quot_raw;
  assign rem_fin  = (signed_q && op1_neg_q) ? (~rem_raw + 32'd1) : rem_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= 6'd0;
      work_q    <= '0;
      divisor_q <= ZeroWord;
      signed_q  <= 1'b0;
      op1_neg_q <= 1'b0;
      op2_neg_q <= 1'b0;
      result_q  <= {ZeroWord, ZeroWord};
      ready_q   <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          ready_q  <= DivResultNotReady;
          result_q <= {ZeroWord, ZeroWord};
          if (start_i == DivStart && !annul_i) begin
            signed_q  <= signed_div_i;
            op1_neg_q <= opdata1_i[31];
            op2_neg_q <= opdata2_i[31];
            cnt_q     <= 6'd0;
            work_q    <= {ZeroWord, op1_abs, 1'b0};
            divisor_q <= op2_abs;
            state_q   <= (opdata2_i == ZeroWord) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            result_q <= {ZeroWord, ZeroWord};
            ready_q  <= DivResultReady;
            state_q  <= DivEnd;
          end
        end
        DivOn: begin
          if (annul_i) begin
            cnt_q   <= 6'd0;
            state_q <= DivFree;
          end else if (cnt_q == 6'd32) begin
            result_q <= {rem_fin, quot_fin};
            ready_q  <= DivResultReady;
            cnt_q    <= 6'd0;
            state_q  <= DivEnd;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 6'd1;
          end
        end
        DivEnd: begin
          // Result is held until the EX stage releases start_i.
          if (start_i == DivStop) begin
            result_q <= {ZeroWord, ZeroWord};
            ready_q  <= DivResultNotReady;
            state_q  <= DivFree;
          end
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed divider bench: the driver queues hand-computed results, a monitor
// pops and compares them on every rising edge of ready_o.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic        ready_prev = 1'b0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one scoreboard pop per completed division.
  always @(negedge clk) begin
    if (ready_o === 1'b1 && ready_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got ready with result 0x%0h, required no result", result_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", result_o, mon_exp);
        $display("result 0x%h checked against 0x%h", result_o, mon_exp);
      end
    end
    ready_prev = ready_o;
  end

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input string tag);
    int n;
    bit got;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp);
    n   = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h5A5A_0001;
        signed_div_i = ~s;
      end
      if (ready_o === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no ready in %0d edges, required %0d", tag, n, lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      start_i = 1'b0;
      return;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
    check({tag, "_hold_result"}, result_o, exp);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  task automatic watch_idle(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (ready_o !== 1'b0) seen++;
    end
    check({tag, "_never_ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 34, "u100_7");
    run_div(1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, "s-7_2");
    run_div(1'b0, 32'd5,          32'd0,        64'h00000000_00000000,  2, "u5_0");
    run_div(1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 34, "umax_1");
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 34, "smin_-1");
    run_div(1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, "s7_-2");
    run_div(1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 34, "ubig_2");
    run_div(1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 34, "s-8_-3");
    run_div(1'b0, 32'd3,          32'd10,       64'h00000003_00000000, 34, "u3_10");
    run_div(1'b1, 32'd0,          32'd0,        64'h00000000_00000000,  2, "s0_0");

    // Annul at iteration 10: nothing queued, so any ready is flagged.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    watch_idle(40, "annul");
    run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34, "u9_3");

    // Reset at iteration 20.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    watch_idle(40, "midrst");
    run_div(1'b0, 32'h12345678, 32'h00000100, 64'h00000078_00123456, 34, "after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameters: none; operand width is fixed at 32 (RegBus) and the result width at 64 (DoubleRegBus).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high (RstEnable); one clock, no other clock domains.
REQ-004 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  32  dividend; sampled with start_i.
REQ-006 opdata2_i  input  32  divisor; sampled with start_i.
REQ-007 start_i  input  1  DivStart request from the EX stage; held high until ready_o is seen.
REQ-008 annul_i  input  1  abort an in-flight division (flush or exception).
REQ-009 result_o  output  64  {remainder[31:0], quotient[31:0]}, registered; EX writes the upper half to HI and the lower half to LO.
REQ-010 ready_o  output  1  DivResultReady; registered.

Function
REQ-011 FSM states SHALL be DivFree, DivByZero, DivOn and DivEnd; the state register SHALL be 2 bits wide.
REQ-012 DivFree: start_i=1 and annul_i=0 SHALL capture the operands; if opdata2_i==0 -> DivByZero, else -> DivOn with cnt=0.
REQ-013 DivFree: start_i=0, or start_i=1 together with annul_i=1 -> remain in DivFree; ready_o=0; result_o=0.
REQ-014 Signed mode SHALL two's-complement-negate a negative operand to its magnitude before iterating; unsigned mode SHALL use the operands as-is.
REQ-015 DivOn working register SHALL be 65 bits, initialised to {32'b0, |dividend|, 1'b0}; the divisor register SHALL hold |divisor|.
REQ-016 Each DivOn cycle SHALL form the 33-bit trial {1'b0, work[63:32]} - {1'b0, divisor}.
REQ-017 Trial negative: work <= work << 1.
REQ-018 Trial non-negative: work <= {trial[31:0], work[31:0], 1'b1}.
REQ-019 After each iteration cnt SHALL increment; exactly 32 iterations (cnt 0..31) SHALL run, and cnt SHALL be 6 bits wide.
REQ-020 When DivOn sees cnt==32, the FSM SHALL latch the result and go to DivEnd.
REQ-021 Quotient = work[31:0], negated if signed and the operand signs differ.
REQ-022 Remainder = work[64:33], negated if signed and the dividend is negative.
REQ-023 DivByZero SHALL go to DivEnd on the next cycle with result 64'h0.
REQ-024 DivEnd SHALL drive ready_o=1 with result_o held stable.
REQ-025 DivEnd with start_i=0 -> DivFree; ready_o and result_o SHALL clear to 0 on that edge.
REQ-026 DivEnd with start_i still 1 -> remain in DivEnd, holding the result.
REQ-027 Latency: ready_o SHALL rise 34 edges after the start-sampling edge (inclusive) for a nonzero divisor, and 2 edges after it for a zero divisor.
REQ-028 annul_i=1 in DivOn or DivByZero SHALL return the FSM to DivFree on the next edge; ready_o SHALL never assert for the annulled operation.
REQ-029 annul_i in DivEnd SHALL have no effect.
REQ-030 Operand changes while the FSM is not in DivFree SHALL be ignored.
REQ-031 -2^31 / -1 (signed) SHALL yield quotient 0x80000000 and remainder 0, with no trap.

Reset
REQ-032 rst=1 at any clock edge SHALL force DivFree, cnt=0, work=0, ready_o=0 and result_o=0, including when reset arrives mid-division.
REQ-033 The first start_i after reset release SHALL be accepted normally.

Structure
REQ-034 The state encodings (DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11) SHALL live in the shared defines file.
REQ-035 The shared defines file SHALL also hold DivStart/DivStop, DivResultReady/DivResultNotReady, RegBus, DoubleRegBus and ZeroWord.
REQ-036 The block SHALL be a single module with no sub-module.
REQ-037 The subtract/shift datapath SHALL be implemented inline.
REQ-038 The EX stage SHALL stall on start_i && !ready_o.

Verification
REQ-039 Unsigned 100/7 -> result_o=64'h00000002_0000000E, with ready_o rising 34 edges after start.
REQ-040 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-041 Divide by zero (5/0) -> ready_o after 2 edges, result_o=0; dropping start_i returns the FSM to DivFree with ready_o=0.
REQ-042 Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-043 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-044 annul_i pulsed at iteration 10 -> DivFree next edge and ready_o never high; a following 9/3 -> result_o=64'h00000000_00000003.
REQ-045 rst pulsed at iteration 20 -> all outputs 0 on the next edge.
